// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for the dual-clock FIFO: qualifies writes against full,
// exports a registered Gray write pointer and synchronizes the read pointer back.
// Optional FIFO_WR_AFULL_EN builds the fill-level and almost-full logic.
module fifo_wr_ctrl #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned AF_THRESH = 56
) (
  input  logic              wr_clk,
  input  logic              wr_rst,
  input  logic              wr_req,
  input  logic [ADDR_W:0]   rd_ptr_gray,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic              wr_full,
  output logic              wr_almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              wr_overflow
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  if (ADDR_W < 2 || AF_THRESH < 1 || AF_THRESH > (1 << ADDR_W)) begin : g_param_err
    $error("fifo_wr_ctrl: ADDR_W must be >= 2 and AF_THRESH within 1..2^ADDR_W");
  end

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] wgray_q, wgray_d;
  logic [PTR_W-1:0] rq1_q, rq2_q;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;

  // Pointer advance, full detection against the synchronized read pointer, sticky overflow
  always_comb begin
    wr_en   = wr_req & ~full_q & ~wr_rst;
    wbin_d  = wbin_q;
    wgray_d = wgray_q;
    if (wr_en) begin
      wbin_d  = wbin_q + PTR_W'(1);
      wgray_d = bin2gray(wbin_d);
    end
    full_d = (wgray_d == {~rq2_q[ADDR_W:ADDR_W-1], rq2_q[ADDR_W-2:0]});
    ovf_d  = ovf_q | (wr_req & full_q);
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= rd_ptr_gray;
      rq2_q   <= rq1_q;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_addr     = wbin_q[ADDR_W-1:0];
  assign wr_ptr_gray = wgray_q;
  assign wr_full     = full_q;
  assign wr_overflow = ovf_q;

`ifdef FIFO_WR_AFULL_EN
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PTR_W-1:0] level_q, level_d;
  logic             afull_q, afull_d;

  // Level uses the post-write pointer and the (stale, pessimistic) synchronized read pointer
  always_comb begin
    level_d = wbin_d - gray2bin(rq2_q);
    afull_d = (level_d >= PTR_W'(AF_THRESH));
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      level_q <= level_d;
      afull_q <= afull_d;
    end
  end

  assign wr_level       = level_q;
  assign wr_almost_full = afull_q;
`else
  assign wr_level       = '0;
  assign wr_almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl (ADDR_W=4, AF_THRESH=12): binary-domain
// reference model plus a write-address scoreboard.
module tb_fifo_wr_ctrl;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned AF_THRESH = 12;
  localparam int unsigned PTR_W     = ADDR_W + 1;
  localparam int          PMOD      = 1 << PTR_W;
  localparam int          DEPTH     = 1 << ADDR_W;
`ifdef FIFO_WR_AFULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic              wr_clk = 1'b0;
  logic              wr_rst = 1'b1;
  logic              wr_req = 1'b0;
  logic [ADDR_W:0]   rd_ptr_gray = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   wr_ptr_gray;
  logic              wr_full;
  logic              wr_almost_full;
  logic [ADDR_W:0]   wr_level;
  logic              wr_overflow;

  fifo_wr_ctrl #(.ADDR_W(ADDR_W), .AF_THRESH(AF_THRESH)) dut (
    .wr_clk         (wr_clk),
    .wr_rst         (wr_rst),
    .wr_req         (wr_req),
    .rd_ptr_gray    (rd_ptr_gray),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_ptr_gray    (wr_ptr_gray),
    .wr_full        (wr_full),
    .wr_almost_full (wr_almost_full),
    .wr_level       (wr_level),
    .wr_overflow    (wr_overflow)
  );

  always #5 wr_clk = ~wr_clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state, binary pointers modulo 2^(ADDR_W+1)
  int m_wbin = 0, m_rq1 = 0, m_rq2 = 0, m_level = 0;
  bit m_full = 0, m_afull = 0, m_ovf = 0;
  logic [ADDR_W-1:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic [PTR_W-1:0] to_gray(input int b);
    logic [PTR_W-1:0] x;
    x = PTR_W'(b);
    return x ^ (x >> 1);
  endfunction

  // One clock: drive at negedge, check wr_en/address before the edge, outputs after it
  task automatic step(input bit req, input bit rst, input int rd_bin);
    bit exp_en;
    bit req_full;
    logic [PTR_W-1:0] prev_gray;
    int lvl;
    @(negedge wr_clk);
    wr_req      = req;
    wr_rst      = rst;
    rd_ptr_gray = to_gray(rd_bin);
    #1;
    exp_en = req & ~m_full & ~rst;
    chk("wr_en", 32'(wr_en), 32'(exp_en));
    if (exp_en) sb_q.push_back(ADDR_W'(m_wbin));
    if (wr_en) begin
      if (sb_q.size() == 0) chk("sb_unexpected_write", 32'(1), 32'(0));
      else chk("wr_addr", 32'(wr_addr), 32'(sb_q.pop_front()));
    end
    prev_gray = wr_ptr_gray;
    @(posedge wr_clk);
    if (rst) begin
      m_wbin = 0; m_rq1 = 0; m_rq2 = 0; m_level = 0;
      m_full = 0; m_afull = 0; m_ovf = 0;
    end else begin
      req_full = req & m_full;
      if (req_full) m_ovf = 1;
      if (exp_en) m_wbin = (m_wbin + 1) % PMOD;
      lvl     = (m_wbin - m_rq2 + PMOD) % PMOD;
      m_level = lvl;
      m_full  = (lvl == DEPTH);
      m_afull = (lvl >= AF_THRESH);
      m_rq2   = m_rq1;
      m_rq1   = rd_bin % PMOD;
    end
    #1;
    chk("wr_ptr_gray", 32'(wr_ptr_gray), 32'(to_gray(m_wbin)));
    chk("wr_full", 32'(wr_full), 32'(m_full));
    chk("wr_overflow", 32'(wr_overflow), 32'(m_ovf));
    chk("wr_level", 32'(wr_level), AF_EN ? 32'(m_level) : 32'(0));
    chk("wr_almost_full", 32'(wr_almost_full), AF_EN ? 32'(m_afull) : 32'(0));
    if (exp_en) chk("gray_one_bit", 32'($countones(prev_gray ^ wr_ptr_gray)), 32'(1));
  endtask

  initial begin
    // Reset with a pending request: no write may leak through
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 0);
    chk("rst_addr", 32'(wr_addr), 32'(0));

    // Fill all 16 slots with the read pointer parked at 0
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 0);
      chk("fill_full", 32'(wr_full), 32'(i == DEPTH - 1));
      chk("fill_afull", 32'(wr_almost_full), AF_EN ? 32'(i >= int'(AF_THRESH) - 1) : 32'(0));
    end
    chk("fill_level", 32'(wr_level), AF_EN ? 32'(DEPTH) : 32'(0));

    // Write while full: dropped, sticky overflow
    step(1'b1, 1'b0, 0);
    chk("ovf_set", 32'(wr_overflow), 32'(1));
    chk("ovf_ptr_hold", 32'(wr_ptr_gray), 32'(to_gray(DEPTH)));
    step(1'b0, 1'b0, 0);
    chk("ovf_sticky", 32'(wr_overflow), 32'(1));

    // Drain visibility: read pointer jumps to 4, seen three edges later
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4);
      chk("drain_full", 32'(wr_full), 32'(i < 2));
    end
    chk("drain_level", 32'(wr_level), AF_EN ? 32'(12) : 32'(0));
    chk("ovf_still_set", 32'(wr_overflow), 32'(1));

    // Mid-operation reset at level 9
    step(1'b0, 1'b1, 0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 0);
    chk("mid_level9", 32'(wr_level), AF_EN ? 32'(9) : 32'(0));
    step(1'b1, 1'b1, 0);
    chk("mid_rst_gray", 32'(wr_ptr_gray), 32'(0));
    chk("mid_rst_ovf", 32'(wr_overflow), 32'(0));
    step(1'b1, 1'b0, 0);
    chk("mid_rst_next_gray", 32'(wr_ptr_gray), 32'(to_gray(1)));

    // Wrap: 40 writes with the read pointer tracking the write pointer
    step(1'b0, 1'b1, 0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, m_wbin);
      if (i >= 2) chk("wrap_level", 32'(wr_level), AF_EN ? 32'(3) : 32'(0));
      if (i == 31) chk("wrap_gray0", 32'(wr_ptr_gray), 32'(0));
      chk("wrap_not_full", 32'(wr_full), 32'(0));
    end
    chk("wrap_final_gray", 32'(wr_ptr_gray), 32'(to_gray(40 % PMOD)));
    chk("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
